elec_chain_ctrl: RTL and testbench

- Parametrised controller for the serial configuration chains of the probe's electrode muxes. Handles NUM_BANK independent chains (e.g. ELEC, ELEC CHEM).
- Takes commands from the SPI command decoder through a valid/ready handshake:
  - write a full chain, with group words pulled from a host stream;
  - non-destructive readback of one group;
  - timed chain reset.
- Generates the divided shift clock internally from the single system clock.
- Generalises the fixed 1024-bit, two-chain, destructive-read control with:
  - per-bank selection;
  - flow-controlled write data;
  - circular readback that preserves chain contents;
  - explicit done/err reporting.

---
 rtl/elec_chain_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_elec_chain_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elec_chain_ctrl.sv
// ============================================================================
//  Module   : elec_chain_ctrl
//  Purpose  : Write, non-destructive readback and reset of NUM_BANK electrode
//             mux configuration chains through a single divided shift clock.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module elec_chain_ctrl #(
    parameter  int NUM_BANK  = 2,
    parameter  int CHAIN_LEN = 1024,
    parameter  int GROUP_WID = 16,
    parameter  int CLK_DIV   = 12,
    parameter  int RST_CYC   = 4,
    localparam int NG        = CHAIN_LEN / GROUP_WID,
    localparam int GAW       = (NG > 1) ? $clog2(NG) : 1,
    localparam int BW        = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_vld,
    output logic                 cmd_rdy,
    input  logic [1:0]           cmd_op,
    input  logic [BW-1:0]        cmd_bank,
    input  logic [GAW-1:0]       cmd_grp,
    output logic                 grp_req,
    output logic [GAW-1:0]       grp_idx,
    input  logic [GROUP_WID-1:0] grp_data,
    input  logic                 grp_vld,
    output logic [GROUP_WID-1:0] rd_data,
    output logic                 rd_vld,
    output logic                 done,
    output logic                 err,
    output logic                 busy,
    output logic [NUM_BANK-1:0]  chain_sclk,
    output logic [NUM_BANK-1:0]  chain_sdi,
    input  logic [NUM_BANK-1:0]  chain_sdo,
    output logic [NUM_BANK-1:0]  chain_rst_n
);

    localparam int DW  = $clog2(CLK_DIV);
    localparam int BCW = (GROUP_WID > 1) ? $clog2(GROUP_WID) : 1;
    localparam int RCW = $clog2(RST_CYC + 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_FETCH     = 3'd1;
    localparam logic [2:0] c_SHIFT_WR  = 3'd2;
    localparam logic [2:0] c_SHIFT_RD  = 3'd3;
    localparam logic [2:0] c_RST_PULSE = 3'd4;
    localparam logic [2:0] c_DONE      = 3'd5;

    localparam logic [1:0] c_OP_WR  = 2'd0;
    localparam logic [1:0] c_OP_RD  = 2'd1;
    localparam logic [1:0] c_OP_BAD = 2'd3;

    localparam logic [DW-1:0]  c_DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0]  c_DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [DW-1:0]  c_DIV_SAMP = DW'(CLK_DIV / 2 - 1);
    localparam logic [BCW-1:0] c_BIT_LAST = BCW'(GROUP_WID - 1);
    localparam logic [GAW-1:0] c_GRP_LAST = GAW'(NG - 1);
    localparam logic [RCW-1:0] c_RST_LAST = RCW'(RST_CYC - 1);

    logic [2:0]           r_state;
    logic [BW-1:0]        r_bank;
    logic [GAW-1:0]       r_rd_grp;
    logic [GAW-1:0]       r_grp;
    logic [BCW-1:0]       r_bit;
    logic [DW-1:0]        r_div;
    logic [RCW-1:0]       r_rcnt;
    logic [GROUP_WID-1:0] r_shreg;
    logic [GROUP_WID-1:0] r_acc;
    logic                 r_sdi;
    logic                 r_is_rd;

    logic w_accept;
    logic w_bad;
    logic w_shifting;
    logic w_sdo;

    assign w_accept   = cmd_vld && cmd_rdy;
    assign w_bad      = (cmd_op == c_OP_BAD) || (32'(cmd_bank) >= NUM_BANK);
    assign w_shifting = (r_state == c_SHIFT_WR) || (r_state == c_SHIFT_RD);
    assign w_sdo      = chain_sdo[r_bank];

    assign cmd_rdy = (r_state == c_IDLE);
    assign busy    = (r_state != c_IDLE);
    assign grp_req = (r_state == c_FETCH);
    assign grp_idx = r_grp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_bank   <= '0;
            r_rd_grp <= '0;
            r_grp    <= '0;
            r_bit    <= '0;
            r_div    <= '0;
            r_rcnt   <= '0;
            r_shreg  <= '0;
            r_acc    <= '0;
            r_sdi    <= 1'b0;
            r_is_rd  <= 1'b0;
            rd_data  <= '0;
            rd_vld   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done   <= 1'b0;
            err    <= 1'b0;
            rd_vld <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_bank   <= cmd_bank;
                        r_rd_grp <= cmd_grp;
                        r_grp    <= c_GRP_LAST;
                        r_bit    <= '0;
                        r_div    <= '0;
                        r_rcnt   <= '0;
                        r_acc    <= '0;
                        r_is_rd  <= (cmd_op == c_OP_RD);
                        if (w_bad) begin
                            err <= 1'b1;
                        end else if (cmd_op == c_OP_WR) begin
                            r_state <= c_FETCH;
                        end else if (cmd_op == c_OP_RD) begin
                            // First recirculated bit is whatever already sits at the chain end.
                            r_sdi   <= chain_sdo[cmd_bank];
                            r_state <= c_SHIFT_RD;
                        end else begin
                            r_state <= c_RST_PULSE;
                        end
                    end
                end
                c_FETCH: begin
                    if (grp_vld) begin
                        r_sdi   <= grp_data[GROUP_WID-1];
                        r_shreg <= grp_data << 1;
                        r_div   <= '0;
                        r_state <= c_SHIFT_WR;
                    end
                end
                c_SHIFT_WR, c_SHIFT_RD: begin
                    r_div <= r_div + 1'b1;
                    if (r_is_rd && (r_div == c_DIV_SAMP) && (r_grp == r_rd_grp)) begin
                        r_acc <= (r_acc << 1) | GROUP_WID'(w_sdo);
                    end
                    if (r_div == c_DIV_LAST) begin
                        r_div <= '0;
                        if (r_bit != c_BIT_LAST) begin
                            r_bit <= r_bit + 1'b1;
                            if (r_is_rd) begin
                                r_sdi <= w_sdo;
                            end else begin
                                r_sdi   <= r_shreg[GROUP_WID-1];
                                r_shreg <= r_shreg << 1;
                            end
                        end else begin
                            r_bit <= '0;
                            if (r_grp == '0) begin
                                r_state <= c_DONE;
                                done    <= 1'b1;
                                rd_vld  <= r_is_rd;
                                if (r_is_rd) begin
                                    rd_data <= r_acc;
                                end
                            end else begin
                                r_grp <= r_grp - 1'b1;
                                if (r_is_rd) begin
                                    r_sdi <= w_sdo;
                                end else begin
                                    r_state <= c_FETCH;
                                end
                            end
                        end
                    end
                end
                c_RST_PULSE: begin
                    if (r_rcnt == c_RST_LAST) begin
                        r_state <= c_DONE;
                        done    <= 1'b1;
                    end else begin
                        r_rcnt <= r_rcnt + 1'b1;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Unselected banks stay parked: sclk/sdi low, rst_n released.
    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        logic w_sel;
        assign w_sel          = (r_bank == BW'(b));
        assign chain_sclk[b]  = w_sel && w_shifting && (r_div >= c_DIV_HALF);
        assign chain_sdi[b]   = w_sel && w_shifting && r_sdi;
        assign chain_rst_n[b] = !rst && !(w_sel && (r_state == c_RST_PULSE));
    end

endmodule

`default_nettype wire

// File: tb/tb_elec_chain_ctrl.sv
// ============================================================================
//  Module   : tb_elec_chain_ctrl
//  Purpose  : Scoreboard bench for elec_chain_ctrl with shift-register chains.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_elec_chain_ctrl;

    localparam int NB     = 2;
    localparam int CL     = 64;
    localparam int GW     = 16;
    localparam int CD     = 4;
    localparam int RC     = 4;
    localparam int NG     = CL / GW;
    localparam int GAW    = 2;
    localparam int BW     = 1;
    localparam int LAT_WR = NG + CL * CD + 1;
    localparam int LAT_RD = CL * CD + 1;
    localparam int LAT_RS = RC + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cmd_vld = 1'b0;
    logic           cmd_rdy;
    logic [1:0]     cmd_op = 2'd0;
    logic [BW-1:0]  cmd_bank = '0;
    logic [GAW-1:0] cmd_grp = '0;
    logic           grp_req;
    logic [GAW-1:0] grp_idx;
    logic [GW-1:0]  grp_data = '0;
    logic           grp_vld = 1'b0;
    logic [GW-1:0]  rd_data;
    logic           rd_vld, done, err, busy;
    logic [NB-1:0]  chain_sclk, chain_sdi, chain_sdo, chain_rst_n;

    always #5 clk = ~clk;

    elec_chain_ctrl #(
        .NUM_BANK(NB), .CHAIN_LEN(CL), .GROUP_WID(GW), .CLK_DIV(CD), .RST_CYC(RC)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op),
        .cmd_bank(cmd_bank), .cmd_grp(cmd_grp),
        .grp_req(grp_req), .grp_idx(grp_idx), .grp_data(grp_data), .grp_vld(grp_vld),
        .rd_data(rd_data), .rd_vld(rd_vld), .done(done), .err(err), .busy(busy),
        .chain_sclk(chain_sclk), .chain_sdi(chain_sdi), .chain_sdo(chain_sdo),
        .chain_rst_n(chain_rst_n)
    );

    // Behavioural chains: shift on rising sclk, sdo is the far end.
    logic [CL-1:0] chain0 = '0;
    logic [CL-1:0] chain1 = '0;
    always @(posedge chain_sclk[0] or negedge chain_rst_n[0])
        if (!chain_rst_n[0]) chain0 <= '0; else chain0 <= {chain0[CL-2:0], chain_sdi[0]};
    always @(posedge chain_sclk[1] or negedge chain_rst_n[1])
        if (!chain_rst_n[1]) chain1 <= '0; else chain1 <= {chain1[CL-2:0], chain_sdi[1]};
    assign chain_sdo = {chain1[CL-1], chain0[CL-1]};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_err;
        bit          has_rd;
        logic [GW-1:0] rd;
        int          at;
    } exp_t;
    exp_t sb[$];

    // Host group source: serves mem[grp_idx] after dly stall cycles, or tied high.
    logic [GW-1:0] mem [NG];
    bit            tie = 1'b1;
    int            dly = 0;
    initial begin
        int scnt;
        scnt = 0;
        forever begin
            @(negedge clk);
            if (tie) begin
                grp_vld  = 1'b1;
                grp_data = mem[grp_idx];
            end else if (grp_req) begin
                if (scnt >= dly) begin
                    grp_vld  = 1'b1;
                    grp_data = mem[grp_idx];
                end else begin
                    grp_vld = 1'b0;
                    scnt++;
                end
            end else begin
                grp_vld = 1'b0;
                scnt    = 0;
            end
        end
    end

    // Response monitor: every done/err/rd_vld consumes one scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (done || err || rd_vld)) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_response done=%0b err=%0b rd_vld=%0b cycle=%0d",
                             done, err, rd_vld, cyc);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if ({err, done, rd_vld} !== {e.is_err, !e.is_err, e.has_rd}) begin
                        errors++;
                        $display("FAIL resp_flags actual err/done/rd_vld=%b%b%b required=%b%b%b",
                                 err, done, rd_vld, e.is_err, !e.is_err, e.has_rd);
                    end
                    checks++;
                    if (cyc != e.at) begin
                        errors++;
                        $display("FAIL resp_latency actual cycle=%0d required=%0d", cyc, e.at);
                    end
                    if (e.has_rd) begin
                        checks++;
                        if (rd_data !== e.rd) begin
                            errors++;
                            $display("FAIL rd_data actual=%h required=%h", rd_data, e.rd);
                        end
                    end
                end
            end
        end
    end

    // Line activity counters, sampled away from the active edge.
    logic [1:0] idxq[$];
    logic [0:0] sel = 1'b0;
    int req_cyc = 0, stall_viol = 0, sclk_cyc = 0, quiet_viol = 0, rlow1 = 0, rise0 = 0;
    logic prev_req = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (grp_req && !prev_req) idxq.push_back(grp_idx);
                if (grp_req) req_cyc++;
                if (grp_req && chain_sclk != '0) stall_viol++;
                if (chain_sclk != '0) sclk_cyc++;
                if (chain_sclk[~sel] || chain_sdi[~sel] || !chain_rst_n[~sel]) quiet_viol++;
                if (!chain_rst_n[1]) rlow1++;
            end
            prev_req = grp_req;
        end
    end
    initial forever begin
        @(posedge chain_sclk[0]);
        rise0++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [BW-1:0] bank, input logic [GAW-1:0] grp,
                         input int lat, input bit is_err, input bit has_rd, input logic [GW-1:0] rd);
        exp_t e;
        @(negedge clk);
        chk("cmd_rdy_idle", {63'd0, cmd_rdy}, 64'd1);
        cmd_vld  = 1'b1;
        cmd_op   = op;
        cmd_bank = bank;
        cmd_grp  = grp;
        e.is_err = is_err;
        e.has_rd = has_rd;
        e.rd     = rd;
        e.at     = cyc + lat;
        sb.push_back(e);
        @(negedge clk);
        cmd_vld = 1'b0;
    endtask

    task automatic wait_resp(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL resp_timeout pending=%0d", sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_idx(input string nm, input int base);
        logic [7:0] v;
        v = '0;
        chk({nm, "_count"}, 64'(idxq.size() - base), 64'd4);
        if (idxq.size() - base == 4)
            for (int k = 0; k < 4; k++) v = {v[5:0], idxq[base + k]};
        chk(nm, {56'd0, v}, 64'hE4);
    endtask

    initial begin
        int b_idx, b_req, b_stall, b_quiet, b_sclk, b_rlow, b_rise;
        mem[3] = 16'hA5A5; mem[2] = 16'h0001; mem[1] = 16'h8000; mem[0] = 16'hFFFF;

        repeat (2) @(negedge clk);
        chk("rst_cmd_rdy", {63'd0, cmd_rdy}, 64'd1);
        chk("rst_busy_req", {62'd0, busy, grp_req}, 64'd0);
        chk("rst_pulses", {61'd0, done, err, rd_vld}, 64'd0);
        chk("rst_chain_lines", {58'd0, chain_sclk, chain_sdi, chain_rst_n}, 64'd0);
        chk("rst_rd_data", {48'd0, rd_data}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_chain_rst_n", {62'd0, chain_rst_n}, 64'd3);

        // Write bank0, data always available
        sel = 1'b0; tie = 1'b1;
        b_idx = idxq.size(); b_req = req_cyc; b_quiet = quiet_viol;
        issue(2'd0, 1'b0, 2'd0, LAT_WR, 1'b0, 1'b0, '0);
        wait_resp(600);
        chk_idx("wr0_grp_idx", b_idx);
        chk("wr0_fetch_cycles", 64'(req_cyc - b_req), 64'd4);
        chk("wr0_chain", chain0, 64'hA5A5_0001_8000_FFFF);
        chk("wr0_bank1_quiet", 64'(quiet_viol - b_quiet), 64'd0);

        // Non-destructive readbacks
        issue(2'd1, 1'b0, 2'd2, LAT_RD, 1'b0, 1'b1, 16'h0001);
        wait_resp(600);
        chk("rd2_chain_kept", chain0, 64'hA5A5_0001_8000_FFFF);
        issue(2'd1, 1'b0, 2'd0, LAT_RD, 1'b0, 1'b1, 16'hFFFF);
        wait_resp(600);
        chk("rd0_chain_kept", chain0, 64'hA5A5_0001_8000_FFFF);

        // Write bank1 with a 7-cycle stall before every group
        mem[3] = 16'h1234; mem[2] = 16'h0F0F; mem[1] = 16'hC3C3; mem[0] = 16'h8001;
        sel = 1'b1; tie = 1'b0; dly = 7;
        b_idx = idxq.size(); b_req = req_cyc; b_stall = stall_viol; b_quiet = quiet_viol;
        issue(2'd0, 1'b1, 2'd0, LAT_WR + 28, 1'b0, 1'b0, '0);
        wait_resp(600);
        chk_idx("wr1_grp_idx", b_idx);
        chk("wr1_fetch_cycles", 64'(req_cyc - b_req), 64'd32);
        chk("wr1_sclk_in_stall", 64'(stall_viol - b_stall), 64'd0);
        chk("wr1_chain", chain1, 64'h1234_0F0F_C3C3_8001);
        chk("wr1_bank0_quiet", 64'(quiet_viol - b_quiet), 64'd0);
        chk("wr1_bank0_kept", chain0, 64'hA5A5_0001_8000_FFFF);

        // Reset pulse on bank1
        b_rlow = rlow1; b_quiet = quiet_viol;
        issue(2'd2, 1'b1, 2'd0, LAT_RS, 1'b0, 1'b0, '0);
        wait_resp(50);
        chk("rst1_low_cycles", 64'(rlow1 - b_rlow), 64'd4);
        chk("rst1_bank0_quiet", 64'(quiet_viol - b_quiet), 64'd0);

        // Reserved opcode is rejected
        sel = 1'b0; b_sclk = sclk_cyc;
        issue(2'd3, 1'b0, 2'd0, 1, 1'b1, 1'b0, '0);
        wait_resp(20);
        repeat (3) @(negedge clk);
        chk("err_no_sclk", 64'(sclk_cyc - b_sclk), 64'd0);
        chk("err_idle_after", {62'd0, cmd_rdy, busy}, 64'd2);
        chk("rd_data_held", {48'd0, rd_data}, 64'h0000_0000_0000_FFFF);

        // Reset asserted at bit 30 of a write
        mem[3] = 16'hCAFE; mem[2] = 16'h0042; mem[1] = 16'h7E81; mem[0] = 16'h5A5A;
        tie = 1'b1; dly = 0; b_rise = rise0;
        issue(2'd0, 1'b0, 2'd0, LAT_WR, 1'b0, 1'b0, '0);
        for (int i = 0; i < 400; i++) begin
            if (rise0 - b_rise >= 31) break;
            @(negedge clk);
        end
        chk("midrst_bit_reached", 64'(rise0 - b_rise), 64'd31);
        rst = 1'b1;
        #1;
        sb.delete();
        chk("midrst_rdy_busy", {62'd0, cmd_rdy, busy}, 64'd2);
        chk("midrst_pulses_req", {60'd0, done, err, rd_vld, grp_req}, 64'd0);
        chk("midrst_chain_lines", {58'd0, chain_sclk, chain_sdi, chain_rst_n}, 64'd0);
        chk("midrst_rd_data", {48'd0, rd_data}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        issue(2'd0, 1'b0, 2'd0, LAT_WR, 1'b0, 1'b0, '0);
        wait_resp(600);
        chk("rewr_chain", chain0, 64'hCAFE_0042_7E81_5A5A);
        issue(2'd1, 1'b0, 2'd1, LAT_RD, 1'b0, 1'b1, 16'h7E81);
        wait_resp(600);
        issue(2'd1, 1'b0, 2'd3, LAT_RD, 1'b0, 1'b1, 16'hCAFE);
        wait_resp(600);
        chk("rewr_chain_kept", chain0, 64'hCAFE_0042_7E81_5A5A);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
